fifo_sum_ctrl: RTL and testbench



---
 rtl/fifo_sum_ctrl_pkg.sv | 17 +
 rtl/fifo_sum_ctrl_sync_fifo.sv | 64 ++++++
 rtl/fifo_sum_ctrl.sv | 136 +++++++++++++
 tb/tb_fifo_sum_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fifo_sum_ctrl_pkg.sv
// Shared constants and types for the FIFO-sum controller slice.
package fifo_sum_ctrl_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned SUM_W            = 10;
    localparam int unsigned DEF_COLS         = 50;
    localparam int unsigned DEF_ROWS         = 50;
    localparam int unsigned DEF_FIFO_DEPTH   = 64;
    localparam int unsigned STB_TO_SUM_LAT   = 3;

    typedef enum logic [1:0] {
        ROW_FILL_A,
        ROW_FILL_B,
        ROW_SUM
    } row_phase_e;

endpackage

// File: rtl/fifo_sum_ctrl_sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy-based full/empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_wr, do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = dout_q;

    // Requests against full/empty are dropped so pointers never move illegally.
    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
        dout_d   = do_rd ? mem_q[rd_ptr_q] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/fifo_sum_ctrl.sv
// Turns the UART byte stream into rows and emits 3-row column sums via two row FIFOs.
module fifo_sum_ctrl
    import fifo_sum_ctrl_pkg::*;
#(
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              sum_valid,
    output logic [SUM_W-1:0]  sum_data
);

    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    if (FIFO_DEPTH < COLS) begin : g_depth_check
        $error("fifo_sum_ctrl: FIFO_DEPTH must be >= COLS");
    end

    logic              rv_meta_q, rv_prev_q;
    logic              byte_stb_q, byte_stb_d;
    logic [BYTE_W-1:0] byte_reg_q, byte_reg_d;
    logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              last_row_q, last_row_d;
    logic              sum_valid_q, sum_valid_d;
    logic [SUM_W-1:0]  sum_data_q, sum_data_d;
    row_phase_e        phase;

    logic              wr_a, wr_b, rd_en;
    logic [BYTE_W-1:0] din_a, din_b, dout_a, dout_b;
    logic              fifo_a_full, fifo_a_empty, fifo_b_full, fifo_b_empty;

    always_comb begin
        byte_stb_d = rv_meta_q && !rv_prev_q;
        byte_reg_d = byte_stb_d ? rx_data : byte_reg_q;

        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (byte_stb_q) begin
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end

        if (row_cnt_q == '0) begin
            phase = ROW_FILL_A;
        end else if (row_cnt_q == ROW_W'(1)) begin
            phase = ROW_FILL_B;
        end else begin
            phase = ROW_SUM;
        end

        rd_en      = byte_stb_q && (phase == ROW_SUM);
        rd_pend_d  = rd_en;
        // Sampled alongside the read so the row counter can advance independently.
        last_row_d = (row_cnt_q == ROW_LAST);

        wr_a  = (byte_stb_q && (phase == ROW_FILL_A)) || (rd_pend_q && !last_row_q);
        wr_b  = (byte_stb_q && (phase == ROW_FILL_B)) || (rd_pend_q && !last_row_q);
        din_a = rd_pend_q ? dout_b : byte_reg_q;
        din_b = byte_reg_q;

        sum_valid_d = rd_pend_q;
        sum_data_d  = rd_pend_q ? SUM_W'(dout_a) + SUM_W'(dout_b) + SUM_W'(byte_reg_q)
                                : sum_data_q;
    end

    // Edge-detect registers reset high so an idle-high rx_valid yields no byte.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_meta_q   <= 1'b1;
            rv_prev_q   <= 1'b1;
            byte_stb_q  <= 1'b0;
            byte_reg_q  <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            last_row_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            sum_data_q  <= '0;
        end else begin
            rv_meta_q   <= rx_valid;
            rv_prev_q   <= rv_meta_q;
            byte_stb_q  <= byte_stb_d;
            byte_reg_q  <= byte_reg_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            rd_pend_q   <= rd_pend_d;
            last_row_q  <= last_row_d;
            sum_valid_q <= sum_valid_d;
            sum_data_q  <= sum_data_d;
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .wr_en (wr_a),
        .din   (din_a),
        .rd_en (rd_en),
        .dout  (dout_a),
        .full  (fifo_a_full),
        .empty (fifo_a_empty)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .wr_en (wr_b),
        .din   (din_b),
        .rd_en (rd_en),
        .dout  (dout_b),
        .full  (fifo_b_full),
        .empty (fifo_b_empty)
    );

    a_no_ovf_a: assert property (@(posedge sys_clk) disable iff (!rst_n) !(wr_a && fifo_a_full));
    a_no_ovf_b: assert property (@(posedge sys_clk) disable iff (!rst_n) !(wr_b && fifo_b_full));
    a_no_udf:   assert property (@(posedge sys_clk) disable iff (!rst_n)
                                 !(rd_en && (fifo_a_empty || fifo_b_empty)));

endmodule

// File: tb/tb_fifo_sum_ctrl.sv
// Directed bench for fifo_sum_ctrl with a 4x4 frame and depth-4 FIFOs.
module tb_fifo_sum_ctrl;
    import fifo_sum_ctrl_pkg::*;

    typedef struct {
        logic [7:0] data;
        bit         exp_v;
        logic [9:0] exp_s;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       sum_valid;
    logic [9:0] sum_data;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_cyc_q[$];
    logic [9:0]  exp_sum_q[$];

    vec_t seq_tbl[16];
    vec_t ff_tbl[16];

    fifo_sum_ctrl #(.COLS(4), .ROWS(4), .FIFO_DEPTH(4)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .sum_valid (sum_valid),
        .sum_data  (sum_data)
    );

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Each sum_valid pulse must match the oldest expected (cycle, value).
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (sum_valid) begin
                n_checks++;
                if (exp_cyc_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_sum: got sum_valid=1 sum_data=%0d at cycle %0d, expected no pulse",
                             sum_data, cyc);
                end else begin
                    int unsigned ec;
                    logic [9:0]  es;
                    ec = exp_cyc_q.pop_front();
                    es = exp_sum_q.pop_front();
                    if (ec != cyc || es != sum_data) begin
                        n_errors++;
                        $display("FAIL sum_pulse: got sum_data=%0d at cycle %0d, expected %0d at cycle %0d",
                                 sum_data, cyc, es, ec);
                    end
                end
            end else if (exp_cyc_q.size() != 0 && cyc >= exp_cyc_q[0]) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_sum: got sum_valid=0 at cycle %0d, expected sum %0d",
                         cyc, exp_sum_q[0]);
                void'(exp_cyc_q.pop_front());
                void'(exp_sum_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Called just after a negedge; returns lo+hi negedges later.
    task automatic send_byte(input vec_t v, input int unsigned lo, input int unsigned hi,
                             input bit toggle);
        rx_valid = 1'b0;
        for (int unsigned i = 0; i < lo; i++) begin
            if (toggle) rx_data = 8'($urandom);
            @(negedge sys_clk);
        end
        rx_data  = v.data;
        rx_valid = 1'b1;
        if (v.exp_v) begin
            exp_cyc_q.push_back(cyc + 1 + STB_TO_SUM_LAT);
            exp_sum_q.push_back(v.exp_s);
        end
        for (int unsigned i = 0; i < hi; i++) @(negedge sys_clk);
    endtask

    task automatic drain_and_check_empty(input string name);
        for (int unsigned i = 0; i < 8; i++) @(negedge sys_clk);
        check({name, "_fifo_a_empty"}, 32'(dut.fifo_a_empty), 1);
        check({name, "_fifo_b_empty"}, 32'(dut.fifo_b_empty), 1);
        check({name, "_pending"}, exp_cyc_q.size(), 0);
    endtask

    initial begin
        int sums[8] = '{15, 18, 21, 24, 27, 30, 33, 36};
        bit stb_seen;

        for (int unsigned i = 0; i < 16; i++) begin
            seq_tbl[i].data  = 8'(i + 1);
            seq_tbl[i].exp_v = (i >= 8);
            seq_tbl[i].exp_s = (i >= 8) ? 10'(sums[i-8]) : 10'd0;
            ff_tbl[i].data   = 8'hFF;
            ff_tbl[i].exp_v  = (i >= 8);
            ff_tbl[i].exp_s  = (i >= 8) ? 10'h2FD : 10'd0;
        end

        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        repeat (3) @(negedge sys_clk);
        check("reset_sum_valid", 32'(sum_valid), 0);
        check("reset_sum_data", 32'(sum_data), 0);
        rst_n = 1'b1;

        stb_seen = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (dut.byte_stb_q || sum_valid) stb_seen = 1'b1;
        end
        check("idle_high_no_stb", 32'(stb_seen), 0);
        check("idle_fifo_a_empty", 32'(dut.fifo_a_empty), 1);
        check("idle_fifo_b_empty", 32'(dut.fifo_b_empty), 1);

        for (int unsigned i = 0; i < 16; i++) begin
            send_byte(seq_tbl[i], 2, 6, 1'b0);
            if (i == 7) begin
                check("rows01_fifo_a_full", 32'(dut.fifo_a_full), 1);
                check("rows01_fifo_b_full", 32'(dut.fifo_b_full), 1);
            end
        end
        drain_and_check_empty("frame1");

        for (int unsigned i = 0; i < 16; i++) send_byte(seq_tbl[i], 2, 6, 1'b0);
        drain_and_check_empty("frame2");

        for (int unsigned i = 0; i < 16; i++) send_byte(ff_tbl[i], 2, 6, 1'b0);
        drain_and_check_empty("frame_ff");

        for (int unsigned i = 0; i < 6; i++) send_byte(seq_tbl[i], 2, 6, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_sum_valid", 32'(sum_valid), 0);
        check("midreset_fifo_a_empty", 32'(dut.fifo_a_empty), 1);
        check("midreset_fifo_b_empty", 32'(dut.fifo_b_empty), 1);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        for (int unsigned i = 0; i < 16; i++) send_byte(seq_tbl[i], 2, 6, 1'b0);
        drain_and_check_empty("after_reset");

        for (int unsigned i = 0; i < 16; i++) send_byte(seq_tbl[i], 1, 3, 1'b1);
        drain_and_check_empty("tight_toggle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
